// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the pipelined adder: default parameter values and
//   the helper that derives the width of one pipeline slice.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_WIDTH_DEFAULT  = 8;
    localparam int ADDER_STAGES_DEFAULT = 2;

    // Each pipeline stage adds an equal share of the operand bits.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage : adder_pkg

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Purely combinational ripple-carry adder for one slice of the operands.
//   Ports:
//     A, B  [W-1:0] in  : slice operands
//     Ci            in  : carry into the least significant bit
//     S     [W-1:0] out : slice sum
//     Co            out : carry out of the most significant bit
// -----------------------------------------------------------------------------
module adder_slice
    import adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Ci,
    output logic [W-1:0] S,
    output logic         Co
);

    // The ripple carry is kept in a procedural variable so the chain is a
    // single ordered evaluation rather than a self-referencing vector.
    always_comb begin
        logic carry;
        carry = Ci;
        S     = '0;
        for (int i = 0; i < W; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Co = carry;
    end

endmodule : adder_slice

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//   Pipelined adder computing {Cout,Sum} = DataA + DataB + Cin. The add is cut
//   into STAGES slices of WIDTH/STAGES bits; slice k is added in stage k, its
//   carry is registered and feeds slice k+1, and the not-yet-added operand
//   bits travel down the pipe with the carry.
//
//   Optional feature: define ADDER_OVF_EN to add the Ovf port, a registered
//   signed-overflow flag produced alongside the final stage.
//
//   Ports:
//     CLK            in  : clock, rising edge
//     RST            in  : synchronous active-high reset
//     In_valid       in  : operand set on DataA/DataB/Cin is valid
//     In_ready       out : operand set is accepted this cycle
//     DataA, DataB   in  : operands [WIDTH-1:0]
//     Cin            in  : carry in
//     Out_valid      out : Sum/Cout(/Ovf) hold a valid result
//     Out_ready      in  : consumer accepts the result
//     Sum            out : result [WIDTH-1:0]
//     Cout           out : unsigned carry out
//     Ovf            out : signed overflow (only with ADDER_OVF_EN)
//
//   Handshake: a transfer happens on any cycle where valid and ready are both
//   1, on the input side and on the output side alike. The pipe stalls only
//   when a result is presented and not taken (Out_valid & ~Out_ready); during
//   a stall every stage freezes and In_ready is 0. In_ready never depends on
//   In_valid, so there is no combinational path from In_valid to In_ready.
// -----------------------------------------------------------------------------
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH_DEFAULT,
    parameter int STAGES = ADDER_STAGES_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             Cin,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int SW   = slice_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (STAGES < 1) begin : g_stages_err
        $error("pipe_adder: STAGES must be at least 1");
    end else if ((WIDTH < 2) || (WIDTH > 64) || ((WIDTH % STAGES) != 0)) begin : g_width_err
        $error("pipe_adder: WIDTH must be 2..64 and divisible by STAGES");
    end

    // Per-stage registers (outputs of stage k).
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             valid_q [STAGES];

    // Per-stage inputs: the primary inputs for stage 0, the previous
    // stage's registers otherwise.
    logic [WIDTH-1:0] stg_a   [STAGES];
    logic [WIDTH-1:0] stg_b   [STAGES];
    logic [WIDTH-1:0] stg_s   [STAGES];
    logic             stg_c   [STAGES];
    logic             stg_v   [STAGES];

    logic [SW-1:0]    slice_s  [STAGES];
    logic             slice_co [STAGES];
    logic [WIDTH-1:0] sum_d    [STAGES];

    logic             stall;

    assign stall     = Out_valid & ~Out_ready;
    assign In_ready  = ~stall;
    assign Out_valid = valid_q[LAST];
    assign Sum       = sum_q[LAST];
    assign Cout      = carry_q[LAST];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stg_a[k] = DataA;
            assign stg_b[k] = DataB;
            assign stg_s[k] = '0;
            assign stg_c[k] = Cin;
            assign stg_v[k] = In_valid;
        end else begin : g_next
            assign stg_a[k] = a_q[k-1];
            assign stg_b[k] = b_q[k-1];
            assign stg_s[k] = sum_q[k-1];
            assign stg_c[k] = carry_q[k-1];
            assign stg_v[k] = valid_q[k-1];
        end

        adder_slice #(
            .W (SW)
        ) u_slice (
            .A  (stg_a[k][k*SW +: SW]),
            .B  (stg_b[k][k*SW +: SW]),
            .Ci (stg_c[k]),
            .S  (slice_s[k]),
            .Co (slice_co[k])
        );

        // Bits from slice k upward are still zero in the partial sum
        // (stage 0 starts from zero and each stage only fills its own slice),
        // so merging the new slice is a plain OR.
        assign sum_d[k] = stg_s[k] | (WIDTH'(slice_s[k]) << (k * SW));
    end

`ifdef ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: same-sign operands giving a result of the other sign.
    assign ovf_d = (stg_a[LAST][WIDTH-1] == stg_b[LAST][WIDTH-1]) &
                   (sum_d[LAST][WIDTH-1] != stg_a[LAST][WIDTH-1]);
    assign Ovf   = ovf_q;
`endif

    // Valid bits advance whenever the pipe is not stalled, so bubbles move
    // down as valid=0. Data registers load only for a valid stage input, which
    // keeps the output data untouched when a bubble reaches the last stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
            end
`ifdef ADDER_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= stg_v[k];
                if (stg_v[k]) begin
                    a_q[k]     <= stg_a[k];
                    b_q[k]     <= stg_b[k];
                    sum_q[k]   <= sum_d[k];
                    carry_q[k] <= slice_co[k];
                end
            end
`ifdef ADDER_OVF_EN
            if (stg_v[LAST]) begin
                ovf_q <= ovf_d;
            end
`endif
        end
    end

endmodule : pipe_adder
